wb_regfile: RTL and testbench
=============================

WB_REGFILE -- requirements
Module: wb_regfile

Interface
REQ-001 SHALL use one clock and one reset: synchronous, active-high.
REQ-002 Port clk, input, 1 bit: rising-edge clock for all state.
REQ-003 Port reset, input, 1 bit: synchronous, active-high, sampled on rising clk.
REQ-004 Port WB_RegWr, input, 1 bit: write enable from the MEM/WB pipeline register.
REQ-005 Port WB_MemtoReg, input, 2 bits: write-data source select.
REQ-006 Port WB_WriteAddr, input, 5 bits: destination register.
REQ-007 Port WB_ReadData, input, 32 bits: memory load data.
REQ-008 Port WB_ALU_result, input, 32 bits: ALU result.
REQ-009 Port WB_PC_next, input, 32 bits: link address.
REQ-010 Ports ID_ReadAddr1 and ID_ReadAddr2, inputs, 5 bits each: decode-stage source registers.
REQ-011 Ports ID_ReadData1 and ID_ReadData2, outputs, 32 bits each: source operands.
REQ-012 Port WB_WriteData, output, 32 bits: selected write-back value, exported for EX forwarding.
REQ-013 Port WB_WriteEn, output, 1 bit: asserted when WB_RegWr=1 and WB_WriteAddr!=0.
REQ-014 Port WB_Count, output, 32 bits: count of committed register writes.

Function
REQ-015 WB_WriteData SHALL be purely combinational from the current inputs.
- WB_MemtoReg=00 -> WB_ALU_result.
- 01 -> WB_ReadData.
- 10 -> WB_PC_next.
- 11 -> WB_ALU_result (reserved encoding).
REQ-016 Commit rule: on each rising clk with reset=0 and WB_WriteEn=1, register[WB_WriteAddr] SHALL take WB_WriteData. No other register changes.
REQ-017 Register 0 SHALL always read 0. Writes to register 0 SHALL be dropped and SHALL NOT increment WB_Count.
REQ-018 ID_ReadDataN SHALL be combinational and SHALL equal register[ID_ReadAddrN].
- Exception (write-through bypass): when WB_WriteEn=1 and WB_WriteAddr=ID_ReadAddrN, ID_ReadDataN SHALL equal WB_WriteData in the same cycle.
REQ-019 Both read ports SHALL operate independently. If both address the same register, both SHALL bypass identically.
REQ-020 WB_Count SHALL increment by 1 on each commit and wrap from 0xFFFFFFFF to 0 without any flag.
REQ-021 Write latency: a value written at edge N SHALL be readable without bypass from edge N onward. Bypass SHALL cover the cycle before edge N.
REQ-022 WB_RegWr=1 with WB_WriteAddr=0 SHALL leave all state unchanged.

Reset
REQ-023 While reset=1 at a rising clk, all registers 1..31 SHALL clear to 0 and WB_Count SHALL clear to 0.
REQ-024 Reset SHALL take priority over a simultaneous commit: the pending write is lost and not counted.
REQ-025 During reset, read ports and WB_WriteData SHALL stay combinational. Bypass SHALL remain active.
REQ-026 Reset deasserted mid-stream SHALL resume normal commits on the first edge where reset=0.

Structure
REQ-027 A shared package SHALL hold:
- the MemtoReg encodings MTR_ALU=00, MTR_MEM=01, MTR_PC=10;
- REG_ZERO=0;
- register count 32 and data width 32.
REQ-028 The write-data select SHALL be one combinational sub-module, wb_data_mux. The storage array, bypass and counter SHALL stay in wb_regfile.

Verification
REQ-029 Reset, then write: reset 2 cycles, then RegWr=1, Addr=5, MemtoReg=00, ALU_result=0x12345678 for one edge -> reg5 reads 0x12345678 and WB_Count=1.
REQ-030 Bypass: same cycle, WriteEn with Addr=8, MemtoReg=01, ReadData=0xDEADBEEF, ID_ReadAddr1=8 -> ID_ReadData1=0xDEADBEEF before the edge.
REQ-031 Zero register: RegWr=1, Addr=0, ALU_result=0xFFFFFFFF -> ID_ReadData1(addr 0)=0, WB_WriteEn=0, WB_Count unchanged.
REQ-032 Link write: MemtoReg=10, PC_next=0x00400024, Addr=31 -> reg31=0x00400024 on the next cycle.
REQ-033 Reset priority: reset=1 and WriteEn=1 (Addr=3) on the same edge -> reg3=0, WB_Count=0.
REQ-034 Counter wrap: force 2^32 commits, or preload via a test hook -> WB_Count goes from 0xFFFFFFFF to 0x00000000.

Source files
------------

// File: rtl/wb_regfile_pkg.sv
// Shared types and constants for the write-back stage register file.
package wb_regfile_pkg;

    localparam int DATA_W    = 32;
    localparam int REG_COUNT = 32;
    localparam int ADDR_W    = $clog2(REG_COUNT);

    typedef logic [DATA_W-1:0] word_t;
    typedef logic [ADDR_W-1:0] regAddr_t;

    // 2'b11 is reserved and resolves to the ALU result.
    typedef enum logic [1:0] {
        MTR_ALU  = 2'b00,
        MTR_MEM  = 2'b01,
        MTR_PC   = 2'b10,
        MTR_RSVD = 2'b11
    } memtoReg_e;

    localparam regAddr_t REG_ZERO = '0;

endpackage

// File: rtl/wb_regfile_if.sv
// Write-back / decode bus of the register file, plus a counter preload test hook.
interface wb_regfile_if;
    import wb_regfile_pkg::*;

    logic       WB_RegWr;
    logic [1:0] WB_MemtoReg;
    regAddr_t   WB_WriteAddr;
    word_t      WB_ReadData;
    word_t      WB_ALU_result;
    word_t      WB_PC_next;
    regAddr_t   ID_ReadAddr1;
    regAddr_t   ID_ReadAddr2;
    word_t      ID_ReadData1;
    word_t      ID_ReadData2;
    word_t      WB_WriteData;
    logic       WB_WriteEn;
    word_t      WB_Count;
    // Test hook: loads WB_Count with cntLoadValue on an edge without reset.
    logic       cntLoad;
    word_t      cntLoadValue;

    modport master (
        output WB_RegWr, WB_MemtoReg, WB_WriteAddr, WB_ReadData, WB_ALU_result,
               WB_PC_next, ID_ReadAddr1, ID_ReadAddr2, cntLoad, cntLoadValue,
        input  ID_ReadData1, ID_ReadData2, WB_WriteData, WB_WriteEn, WB_Count
    );

    modport slave (
        input  WB_RegWr, WB_MemtoReg, WB_WriteAddr, WB_ReadData, WB_ALU_result,
               WB_PC_next, ID_ReadAddr1, ID_ReadAddr2, cntLoad, cntLoadValue,
        output ID_ReadData1, ID_ReadData2, WB_WriteData, WB_WriteEn, WB_Count
    );

endinterface

// File: rtl/wb_data_mux.sv
// Write-back data select: picks ALU result, load data or link address.
module wb_data_mux
    import wb_regfile_pkg::*;
(
    input  logic [1:0] memtoReg,
    input  word_t      aluResult,
    input  word_t      readData,
    input  word_t      pcNext,
    output word_t      writeData
);

    always_comb begin
        writeData = aluResult;
        case (memtoReg)
            MTR_MEM: writeData = readData;
            MTR_PC:  writeData = pcNext;
            default: writeData = aluResult;
        endcase
    end

endmodule

// File: rtl/wb_regfile.sv
// 32x32 register file with write-through bypass and a committed-write counter.
module wb_regfile
    import wb_regfile_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    wb_regfile_if.slave bus
);

    word_t regs [REG_COUNT];
    word_t count;
    word_t writeData;
    logic  writeEn;
    word_t rd1;
    word_t rd2;

    wb_data_mux uDataMux (
        .memtoReg  (bus.WB_MemtoReg),
        .aluResult (bus.WB_ALU_result),
        .readData  (bus.WB_ReadData),
        .pcNext    (bus.WB_PC_next),
        .writeData (writeData)
    );

    assign writeEn = bus.WB_RegWr && (bus.WB_WriteAddr != REG_ZERO);

    // Reset wins over a same-edge commit; register 0 is never written.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < REG_COUNT; i++) begin
                regs[i] <= '0;
            end
            count <= '0;
        end else begin
            if (writeEn) begin
                regs[bus.WB_WriteAddr] <= writeData;
                count                  <= count + word_t'(1);
            end
            if (bus.cntLoad) begin
                count <= bus.cntLoadValue;
            end
        end
    end

    // Bypass stays live during reset; writeEn already excludes register 0.
    always_comb begin
        rd1 = (bus.ID_ReadAddr1 == REG_ZERO) ? '0 : regs[bus.ID_ReadAddr1];
        if (writeEn && (bus.ID_ReadAddr1 == bus.WB_WriteAddr)) begin
            rd1 = writeData;
        end
        rd2 = (bus.ID_ReadAddr2 == REG_ZERO) ? '0 : regs[bus.ID_ReadAddr2];
        if (writeEn && (bus.ID_ReadAddr2 == bus.WB_WriteAddr)) begin
            rd2 = writeData;
        end
    end

    assign bus.ID_ReadData1 = rd1;
    assign bus.ID_ReadData2 = rd2;
    assign bus.WB_WriteData = writeData;
    assign bus.WB_WriteEn   = writeEn;
    assign bus.WB_Count     = count;

endmodule

// File: tb/tb_wb_regfile.sv
// Self-checking bench for wb_regfile: vector table, random writes, reset and wrap sequences.
module tb_wb_regfile;

    typedef struct {
        logic        regWr;
        logic [1:0]  mtr;
        logic [4:0]  waddr;
        logic [31:0] rdata;
        logic [31:0] alu;
        logic [31:0] pc;
        logic [4:0]  ra1;
        logic [4:0]  ra2;
        logic [31:0] expWd;
        logic        expWen;
    } vec_t;

    logic clk = 1'b0;
    logic reset;

    wb_regfile_if bus ();

    wb_regfile dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] shadow [32];
    logic [31:0] expCount;
    logic [31:0] exp_q [$];
    vec_t        vecs [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] muxModel(input logic [1:0] mtr, input logic [31:0] alu,
                                             input logic [31:0] rdata, input logic [31:0] pc);
        case (mtr)
            2'b01:   return rdata;
            2'b10:   return pc;
            default: return alu;
        endcase
    endfunction

    task automatic driveVec(input vec_t v);
        bus.WB_RegWr      = v.regWr;
        bus.WB_MemtoReg   = v.mtr;
        bus.WB_WriteAddr  = v.waddr;
        bus.WB_ReadData   = v.rdata;
        bus.WB_ALU_result = v.alu;
        bus.WB_PC_next    = v.pc;
        bus.ID_ReadAddr1  = v.ra1;
        bus.ID_ReadAddr2  = v.ra2;
    endtask

    task automatic popCount(input string name);
        if (exp_q.size() == 0) begin
            check({name, "_qempty"}, 32'd1, 32'd0);
        end else begin
            check(name, bus.WB_Count, exp_q.pop_front());
        end
    endtask

    // One cycle: drive at negedge, check combinational outputs, commit at posedge, check count.
    task automatic doStep(input string name, input vec_t v, input logic rst);
        logic [31:0] e1;
        logic [31:0] e2;
        @(negedge clk);
        reset = rst;
        driveVec(v);
        #1;
        e1 = (v.expWen && v.ra1 == v.waddr) ? v.expWd : shadow[v.ra1];
        e2 = (v.expWen && v.ra2 == v.waddr) ? v.expWd : shadow[v.ra2];
        check({name, "_wdata"}, bus.WB_WriteData, v.expWd);
        check({name, "_wen"}, {31'd0, bus.WB_WriteEn}, {31'd0, v.expWen});
        check({name, "_rd1"}, bus.ID_ReadData1, e1);
        check({name, "_rd2"}, bus.ID_ReadData2, e2);
        if (rst) begin
            for (int i = 0; i < 32; i++) shadow[i] = '0;
            expCount = '0;
        end else if (v.expWen) begin
            shadow[v.waddr] = v.expWd;
            expCount = expCount + 32'd1;
        end
        exp_q.push_back(expCount);
        @(posedge clk);
        #1;
        popCount({name, "_count"});
    endtask

    initial begin
        vec_t v;
        vec_t idle;
        idle = '{1'b0, 2'b00, 5'd0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 32'h0, 1'b0};

        // Clock/reset block: two reset edges, then check the cleared state.
        reset            = 1'b1;
        bus.cntLoad      = 1'b0;
        bus.cntLoadValue = '0;
        driveVec(idle);
        for (int i = 0; i < 32; i++) shadow[i] = '0;
        expCount = '0;
        repeat (2) @(posedge clk);
        #1;
        bus.ID_ReadAddr1 = 5'd5;
        bus.ID_ReadAddr2 = 5'd31;
        #1;
        check("reset_count", bus.WB_Count, 32'h0);
        check("reset_rd5", bus.ID_ReadData1, 32'h0);
        check("reset_rd31", bus.ID_ReadData2, 32'h0);

        //          regWr mtr    waddr  rdata         alu           pc            ra1    ra2    expWd         expWen
        vecs[0] = '{1'b1, 2'b00, 5'd5,  32'h0,        32'h12345678, 32'h0,        5'd5,  5'd0,  32'h12345678, 1'b1};
        vecs[1] = '{1'b1, 2'b01, 5'd8,  32'hDEADBEEF, 32'h11111111, 32'h22222222, 5'd8,  5'd5,  32'hDEADBEEF, 1'b1};
        vecs[2] = '{1'b0, 2'b00, 5'd8,  32'h0,        32'hCAFEF00D, 32'h0,        5'd8,  5'd8,  32'hCAFEF00D, 1'b0};
        vecs[3] = '{1'b1, 2'b00, 5'd0,  32'h0,        32'hFFFFFFFF, 32'h0,        5'd0,  5'd0,  32'hFFFFFFFF, 1'b0};
        vecs[4] = '{1'b1, 2'b10, 5'd31, 32'h0,        32'h00000033, 32'h00400024, 5'd31, 5'd31, 32'h00400024, 1'b1};
        vecs[5] = '{1'b1, 2'b11, 5'd12, 32'h00000044, 32'h0BADC0DE, 32'h00000055, 5'd31, 5'd12, 32'h0BADC0DE, 1'b1};
        vecs[6] = '{1'b1, 2'b01, 5'd5,  32'hA5A5A5A5, 32'h0,        32'h0,        5'd5,  5'd12, 32'hA5A5A5A5, 1'b1};
        vecs[7] = '{1'b0, 2'b10, 5'd5,  32'h0,        32'h0,        32'h00001000, 5'd5,  5'd8,  32'h00001000, 1'b0};
        for (int i = 0; i < 8; i++) begin
            doStep($sformatf("vec%0d", i), vecs[i], 1'b0);
        end

        // Random write traffic against the shadow model.
        for (int i = 0; i < 24; i++) begin
            v.regWr  = 1'($urandom_range(1, 0));
            v.mtr    = 2'($urandom_range(3, 0));
            v.waddr  = 5'($urandom_range(31, 0));
            v.rdata  = $urandom;
            v.alu    = $urandom;
            v.pc     = $urandom;
            v.ra1    = ($urandom_range(1, 0) == 1) ? v.waddr : 5'($urandom_range(31, 0));
            v.ra2    = 5'($urandom_range(31, 0));
            v.expWd  = muxModel(v.mtr, v.alu, v.rdata, v.pc);
            v.expWen = v.regWr && (v.waddr != 5'd0);
            doStep($sformatf("rnd%0d", i), v, 1'b0);
        end

        // Reset beats a same-edge write to r3; bypass still visible during reset.
        v = '{1'b1, 2'b00, 5'd3, 32'h0, 32'h00000077, 32'h0, 5'd3, 5'd5, 32'h00000077, 1'b1};
        doStep("rst_prio", v, 1'b1);
        // First edge after reset commits again.
        v = '{1'b1, 2'b00, 5'd4, 32'h0, 32'h00000044, 32'h0, 5'd3, 5'd5, 32'h00000044, 1'b1};
        doStep("resume", v, 1'b0);
        v = '{1'b0, 2'b00, 5'd0, 32'h0, 32'h0, 32'h0, 5'd4, 5'd31, 32'h0, 1'b0};
        doStep("resume_rd", v, 1'b0);

        // Counter wrap via the preload hook.
        @(negedge clk);
        driveVec(idle);
        bus.cntLoad      = 1'b1;
        bus.cntLoadValue = 32'hFFFFFFFE;
        expCount = 32'hFFFFFFFE;
        exp_q.push_back(expCount);
        @(posedge clk);
        #1;
        popCount("preload");
        @(negedge clk);
        bus.cntLoad = 1'b0;
        v = '{1'b1, 2'b00, 5'd9, 32'h0, 32'h00000009, 32'h0, 5'd9, 5'd0, 32'h00000009, 1'b1};
        doStep("wrap_max", v, 1'b0);
        check("wrap_at_max", bus.WB_Count, 32'hFFFFFFFF);
        v = '{1'b1, 2'b00, 5'd10, 32'h0, 32'h0000000A, 32'h0, 5'd10, 5'd9, 32'h0000000A, 1'b1};
        doStep("wrap_zero", v, 1'b0);
        check("wrap_to_zero", bus.WB_Count, 32'h0);

        if (exp_q.size() != 0) begin
            check("queue_drained", 32'(exp_q.size()), 32'd0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
